// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC and the fetch/data phase bit, and loads the IF/ID register.
// Latency: an instruction at PC p reaches IF/ID two clocks after pc_out becomes p. Throughput is one instruction per two clocks.
// Backpressure: stall holds the PC and IF/ID on advance edges. A redirect overrides a stall and injects a bubble.
module if_stage #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0033
) (
    input  logic            clk,
    input  logic            rst,
    output logic            tick_tock,
    output logic [XLEN-1:0] mem_addr,
    input  logic [31:0]     mem_rdata,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] IF_ID_PC,
    output logic [31:0]     IF_ID_Inst,
    output logic            IF_ID_valid,
    output logic            fetch_err,
    output logic [31:0]     fetched_count
);

    // Word captured on the fetch edge. It is consumed on the following advance edge.
    logic [31:0] fetch_buf;

    // The memory sees the fetch PC all the time.
    // While tick_tock is high, the top-level mux routes the data address to the memory instead.
    assign mem_addr = pc_out;

    // Phase toggle, plus a fetch-edge capture and an advance-edge update.
    // On the advance edge the priority is redirect, then stall, then a normal advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_tock     <= 1'b0;
            pc_out        <= RESET_PC;
            IF_ID_PC      <= '0;
            IF_ID_Inst    <= NOP_INSTR;
            IF_ID_valid   <= 1'b0;
            fetch_err     <= 1'b0;
            fetched_count <= '0;
            fetch_buf     <= NOP_INSTR;
        end else begin
            tick_tock <= ~tick_tock;
            if (!tick_tock) begin
                // Fetch edge: only the buffer moves. A stalled PC simply re-reads the same word.
                fetch_buf <= mem_rdata;
            end else if (redirect_valid) begin
                // The target is forced to word alignment. Any dropped low bits are flagged for one advance period.
                pc_out      <= {redirect_pc[XLEN-1:2], 2'b00};
                IF_ID_PC    <= '0;
                IF_ID_Inst  <= NOP_INSTR;
                IF_ID_valid <= 1'b0;
                fetch_err   <= |redirect_pc[1:0];
            end else if (stall) begin
                fetch_err <= 1'b0;
            end else begin
                IF_ID_Inst    <= fetch_buf;
                IF_ID_PC      <= pc_out;
                IF_ID_valid   <= 1'b1;
                pc_out        <= pc_out + XLEN'(4);
                fetched_count <= fetched_count + 32'd1;
                fetch_err     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage. It uses a memory whose word at byte address 4k is 0x1000_0000 + k.
// Inputs change on the falling edge, and outputs are compared on the falling edge.
// The bench prints a pass/total summary line at the end.
`timescale 1ns/1ps
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        tick_tock;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] pc_out;
    logic [31:0] IF_ID_PC;
    logic [31:0] IF_ID_Inst;
    logic        IF_ID_valid;
    logic        fetch_err;
    logic [31:0] fetched_count;

    int n_chk  = 0;
    int n_pass = 0;

    if_stage dut (
        .clk           (clk),
        .rst           (rst),
        .tick_tock     (tick_tock),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .pc_out        (pc_out),
        .IF_ID_PC      (IF_ID_PC),
        .IF_ID_Inst    (IF_ID_Inst),
        .IF_ID_valid   (IF_ID_valid),
        .fetch_err     (fetch_err),
        .fetched_count (fetched_count)
    );

    // Combinational unified memory: word k holds 0x1000_0000 + k.
    assign mem_rdata = 32'h1000_0000 + {2'b00, mem_addr[31:2]};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic clk1();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One instruction cycle: a fetch edge followed by an advance edge, checking the phase after each.
    task automatic instr_cycle();
        clk1();
        check("tt_after_fetch", {31'b0, tick_tock}, 32'd1);
        clk1();
        check("tt_after_adv", {31'b0, tick_tock}, 32'd0);
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                              input logic vld, input logic [31:0] cnt);
        check({tag, "_pc_out"}, pc_out, pc);
        check({tag, "_ifid_inst"}, IF_ID_Inst, inst);
        check({tag, "_ifid_valid"}, {31'b0, IF_ID_valid}, {31'b0, vld});
        check({tag, "_count"}, fetched_count, cnt);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_tt"}, {31'b0, tick_tock}, 32'd0);
        check({tag, "_pc"}, pc_out, 32'h0);
        check({tag, "_mem_addr"}, mem_addr, 32'h0);
        check({tag, "_ifid_pc"}, IF_ID_PC, 32'h0);
        check({tag, "_ifid_inst"}, IF_ID_Inst, 32'h0000_0033);
        check({tag, "_ifid_valid"}, {31'b0, IF_ID_valid}, 32'd0);
        check({tag, "_err"}, {31'b0, fetch_err}, 32'd0);
        check({tag, "_count"}, fetched_count, 32'd0);
    endtask

    initial begin
        rst            = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        @(negedge clk);
        check_reset("reset");
        rst = 1'b0;

        // Straight-line fetch for two advances.
        for (int i = 1; i <= 2; i++) begin
            instr_cycle();
            check_ifid("seq", 32'(4 * i), 32'h1000_0000 + 32'(i - 1), 1'b1, 32'(i));
            check("seq_ifid_pc", IF_ID_PC, 32'(4 * (i - 1)));
        end

        // Stall for three advance edges while pc_out is 8.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instr_cycle();
            check_ifid("stall", 32'h8, 32'h1000_0001, 1'b1, 32'd2);
            check("stall_ifid_pc", IF_ID_PC, 32'h4);
        end
        stall = 1'b0;
        instr_cycle();
        check_ifid("unstall", 32'hC, 32'h1000_0002, 1'b1, 32'd3);
        check("unstall_ifid_pc", IF_ID_PC, 32'h8);
        instr_cycle();
        check_ifid("seq4", 32'h10, 32'h1000_0003, 1'b1, 32'd4);
        check("seq4_ifid_pc", IF_ID_PC, 32'hC);

        // A redirect that arrives together with a stall: the redirect wins.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        stall          = 1'b1;
        instr_cycle();
        check_ifid("redir", 32'h40, 32'h0000_0033, 1'b0, 32'd4);
        check("redir_ifid_pc", IF_ID_PC, 32'h0);
        check("redir_err", {31'b0, fetch_err}, 32'd0);
        redirect_valid = 1'b0;
        stall          = 1'b0;
        instr_cycle();
        check_ifid("post_redir", 32'h44, 32'h1000_0010, 1'b1, 32'd5);
        check("post_redir_ifid_pc", IF_ID_PC, 32'h40);

        // A misaligned redirect target produces a one-advance-period error pulse.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        instr_cycle();
        redirect_valid = 1'b0;
        check("mis_pc", pc_out, 32'h40);
        check("mis_err", {31'b0, fetch_err}, 32'd1);
        check("mis_count", fetched_count, 32'd5);
        clk1();
        check("mis_err_hold", {31'b0, fetch_err}, 32'd1);
        clk1();
        check("mis_err_clear", {31'b0, fetch_err}, 32'd0);
        check_ifid("mis_next", 32'h44, 32'h1000_0010, 1'b1, 32'd6);

        // PC wrap-around, plus a count preloaded near its maximum.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        instr_cycle();
        redirect_valid = 1'b0;
        check("wrap_redir_pc", pc_out, 32'hFFFF_FFFC);
        force dut.fetched_count = 32'hFFFF_FFFE;
        #1;
        release dut.fetched_count;
        instr_cycle();
        check_ifid("wrap", 32'h0, 32'h4FFF_FFFF, 1'b1, 32'hFFFF_FFFF);
        check("wrap_ifid_pc", IF_ID_PC, 32'hFFFF_FFFC);
        instr_cycle();
        check_ifid("cnt_wrap", 32'h4, 32'h1000_0000, 1'b1, 32'h0);

        // Mid-operation asynchronous reset at pc_out = 0x20 with tick_tock = 1.
        for (int i = 0; i < 7; i++) instr_cycle();
        check("pre_rst_pc", pc_out, 32'h20);
        clk1();
        check("pre_rst_tt", {31'b0, tick_tock}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_reset("async_rst");
        rst = 1'b0;
        instr_cycle();
        check_ifid("after_rst", 32'h4, 32'h1000_0000, 1'b1, 32'd1);
        check("after_rst_ifid_pc", IF_ID_PC, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
